alsu: RTL and testbench

//  Registered arithmetic/logic/shift unit on two 3-bit operands with a 6-bit result.

---
 rtl/alsu.sv | 105 ++++++++++
 tb/tb_alsu.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/alsu.sv
// Registered 3-bit arithmetic/logic/shift unit with a 6-bit result.
// Inputs are captured one clock, and the result and invalid-op LED blink are registered the next.
module alsu #(
  parameter string INPUT_PRIORITY = "A",
  parameter string FULL_ADDER     = "ON"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  A,
  input  logic [2:0]  B,
  input  logic [2:0]  opcode,
  input  logic        cin,
  input  logic        serial_in,
  input  logic        direction,
  input  logic        red_op_A,
  input  logic        red_op_B,
  input  logic        bypass_A,
  input  logic        bypass_B,
  output logic [5:0]  out,
  output logic [15:0] leds
);

  localparam bit PRI_A   = (INPUT_PRIORITY != "B");
  localparam bit USE_CIN = (FULL_ADDER == "ON");

  logic [2:0] a_r, b_r, op_r;
  logic       cin_r, ser_r, dir_r, ra_r, rb_r, ba_r, bb_r;

  logic       invalid;
  logic [2:0] red_src;
  logic [2:0] byp_src;
  logic [5:0] result;
  logic [5:0] out_next;

  // Reduction requests are only meaningful for the AND/XOR opcodes.
  assign invalid = (op_r[2] & op_r[1]) | ((ra_r | rb_r) & (op_r[2:1] != 2'b00));

  always_comb begin
    red_src = b_r;
    if (ra_r && rb_r)
      red_src = PRI_A ? a_r : b_r;
    else if (ra_r)
      red_src = a_r;
  end

  always_comb begin
    byp_src = b_r;
    if (ba_r && bb_r)
      byp_src = PRI_A ? a_r : b_r;
    else if (ba_r)
      byp_src = a_r;
  end

  always_comb begin
    result = '0;
    case (op_r)
      3'd0: result = (ra_r | rb_r) ? {5'b0, &red_src} : {3'b0, a_r & b_r};
      3'd1: result = (ra_r | rb_r) ? {5'b0, ^red_src} : {3'b0, a_r ^ b_r};
      3'd2: result = {3'b0, a_r} + {3'b0, b_r} + {5'b0, cin_r & USE_CIN};
      3'd3: result = {3'b0, a_r} * {3'b0, b_r};
      3'd4: result = dir_r ? {out[4:0], ser_r} : {ser_r, out[5:1]};
      3'd5: result = dir_r ? {out[4:0], out[5]} : {out[0], out[5:1]};
      default: result = '0;
    endcase
  end

  always_comb begin
    out_next = result;
    if (ba_r || bb_r)
      out_next = {3'b0, byp_src};
    else if (invalid)
      out_next = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r   <= '0;
      b_r   <= '0;
      op_r  <= '0;
      cin_r <= 1'b0;
      ser_r <= 1'b0;
      dir_r <= 1'b0;
      ra_r  <= 1'b0;
      rb_r  <= 1'b0;
      ba_r  <= 1'b0;
      bb_r  <= 1'b0;
      out   <= '0;
      leds  <= '0;
    end else begin
      a_r   <= A;
      b_r   <= B;
      op_r  <= opcode;
      cin_r <= cin;
      ser_r <= serial_in;
      dir_r <= direction;
      ra_r  <= red_op_A;
      rb_r  <= red_op_B;
      ba_r  <= bypass_A;
      bb_r  <= bypass_B;
      out   <= out_next;
      leds  <= invalid ? ~leds : 16'h0000;
    end
  end

endmodule

// File: tb/tb_alsu.sv
// Directed bench for alsu: default instance plus a B-priority, half-adder instance.
// Table vectors for steady-state ops, hand sequences for blink, shift/rotate and reset.
`timescale 1ns/1ps
module tb_alsu;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  A, B, opcode;
  logic        cin, serial_in, direction;
  logic        red_op_A, red_op_B, bypass_A, bypass_B;
  logic [5:0]  out, out2;
  logic [15:0] leds, leds2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alsu dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .opcode(opcode), .cin(cin),
    .serial_in(serial_in), .direction(direction),
    .red_op_A(red_op_A), .red_op_B(red_op_B),
    .bypass_A(bypass_A), .bypass_B(bypass_B),
    .out(out), .leds(leds)
  );

  alsu #(.INPUT_PRIORITY("B"), .FULL_ADDER("OFF")) dut2 (
    .clk(clk), .rst(rst), .A(A), .B(B), .opcode(opcode), .cin(cin),
    .serial_in(serial_in), .direction(direction),
    .red_op_A(red_op_A), .red_op_B(red_op_B),
    .bypass_A(bypass_A), .bypass_B(bypass_B),
    .out(out2), .leds(leds2)
  );

  typedef struct {
    logic [2:0]  a, b, op;
    logic        ci, ra, rb, ba, bb;
    logic [5:0]  exp_out;
    logic [5:0]  exp_out2;
    logic [15:0] exp_leds;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] a, input logic [2:0] b, input logic [2:0] op,
                       input logic ci, input logic ra, input logic rb,
                       input logic ba, input logic bb);
    A = a; B = b; opcode = op; cin = ci;
    red_op_A = ra; red_op_B = rb; bypass_A = ba; bypass_B = bb;
  endtask

  task automatic drive_sr(input logic [2:0] op, input logic dir, input logic ser);
    opcode = op; direction = dir; serial_in = ser;
    red_op_A = 0; red_op_B = 0; bypass_A = 0; bypass_B = 0;
  endtask

  initial begin
    //              a  b  op ci ra rb ba bb  out out2 leds
    vecs.push_back('{3'd1, 3'd2, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd1,  6'd1,  16'h0000});
    vecs.push_back('{3'd1, 3'd2, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd2,  6'd2,  16'h0000});
    vecs.push_back('{3'd1, 3'd2, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd1,  6'd2,  16'h0000});
    vecs.push_back('{3'd1, 3'd7, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0,  6'd0,  16'h0000});
    vecs.push_back('{3'd1, 3'd7, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd1,  6'd1,  16'h0000});
    vecs.push_back('{3'd1, 3'd7, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0,  6'd1,  16'h0000});
    vecs.push_back('{3'd1, 3'd7, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd1,  6'd1,  16'h0000});
    vecs.push_back('{3'd0, 3'd1, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0,  6'd0,  16'h0000});
    vecs.push_back('{3'd0, 3'd1, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd1,  6'd1,  16'h0000});
    vecs.push_back('{3'd0, 3'd1, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0,  6'd1,  16'h0000});
    vecs.push_back('{3'd0, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd1,  6'd1,  16'h0000});
    vecs.push_back('{3'd0, 3'd1, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0,  6'd0,  16'hFFFF});
    vecs.push_back('{3'd7, 3'd7, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd15, 6'd14, 16'h0000});
    vecs.push_back('{3'd7, 3'd7, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd49, 6'd49, 16'h0000});
    vecs.push_back('{3'd5, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd1,  6'd1,  16'h0000});
    vecs.push_back('{3'd5, 3'd3, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd6,  6'd6,  16'h0000});
    vecs.push_back('{3'd7, 3'd7, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  6'd0,  16'hFFFF});
    vecs.push_back('{3'd5, 3'd3, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd5,  6'd5,  16'hFFFF});
    vecs.push_back('{3'd2, 3'd3, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd5,  6'd5,  16'h0000});

    // Reset with arbitrary inputs applied
    rst = 1'b1;
    serial_in = 1'b1; direction = 1'b1;
    drive(3'd5, 3'd6, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(3);
    check("reset_out", {10'b0, out}, 16'd0);
    check("reset_leds", leds, 16'h0000);
    check("reset_out2", {10'b0, out2}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    serial_in = 1'b0; direction = 1'b0;
    drive(3'd1, 3'd1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(2);
    check("add_cin_out", {10'b0, out}, 16'd3);
    check("add_nocin_out2", {10'b0, out2}, 16'd2);
    check("add_leds", leds, 16'h0000);

    foreach (vecs[i]) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].ci,
            vecs[i].ra, vecs[i].rb, vecs[i].ba, vecs[i].bb);
      tick(2);
      check($sformatf("vec%0d_out", i), {10'b0, out}, {10'b0, vecs[i].exp_out});
      check($sformatf("vec%0d_out2", i), {10'b0, out2}, {10'b0, vecs[i].exp_out2});
      check($sformatf("vec%0d_leds", i), leds, vecs[i].exp_leds);
    end

    // Held invalid opcode: leds toggle every clock once the opcode is registered
    drive(3'd2, 3'd3, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);
    check("blink_leds0", leds, 16'h0000);
    tick(1);
    check("blink_leds1", leds, 16'hFFFF);
    check("blink_out", {10'b0, out}, 16'd0);
    tick(1);
    check("blink_leds2", leds, 16'h0000);
    tick(1);
    check("blink_leds3", leds, 16'hFFFF);
    check("blink_leds3_b", leds2, 16'hFFFF);
    drive(3'd2, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(2);
    check("blink_clear_leds", leds, 16'h0000);
    check("blink_clear_out", {10'b0, out}, 16'd2);

    // Shift/rotate: each opcode held for exactly one registered cycle
    drive(3'd3, 3'd2, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    serial_in = 1'b0; direction = 1'b0;
    tick(2);
    check("mul_out", {10'b0, out}, 16'd6);
    drive_sr(3'd4, 1'b1, 1'b0);
    tick(1);
    check("sr_pipe_out", {10'b0, out}, 16'd6);
    drive_sr(3'd4, 1'b0, 1'b0);
    tick(1);
    check("shl_out", {10'b0, out}, 16'd12);
    drive_sr(3'd5, 1'b1, 1'b0);
    tick(1);
    check("shr_out", {10'b0, out}, 16'd6);
    drive_sr(3'd5, 1'b0, 1'b0);
    tick(1);
    check("rol_out", {10'b0, out}, 16'd12);
    drive(3'd1, 3'd2, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);
    check("ror_out", {10'b0, out}, 16'd6);
    check("ror_out2", {10'b0, out2}, 16'd6);
    tick(1);
    check("add3_out", {10'b0, out}, 16'd3);

    // Wrap-around corners of rotate and serial fill
    drive_sr(3'd5, 1'b0, 1'b0);
    tick(1);
    check("wrap_pipe", {10'b0, out}, 16'd3);
    drive_sr(3'd5, 1'b1, 1'b0);
    tick(1);
    check("ror_wrap", {10'b0, out}, 16'b100001);
    drive_sr(3'd4, 1'b0, 1'b1);
    tick(1);
    check("rol_wrap", {10'b0, out}, 16'b000011);
    drive(3'd1, 3'd2, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);
    check("shr_fill1", {10'b0, out}, 16'b100001);
    check("shr_fill1_b", {10'b0, out2}, 16'b100001);
    tick(1);
    check("shr_hold_add", {10'b0, out}, 16'd3);

    // Held shift keeps moving one position per clock
    drive_sr(3'd4, 1'b1, 1'b1);
    tick(2);
    check("shl_hold1", {10'b0, out}, 16'b000111);
    tick(1);
    check("shl_hold2", {10'b0, out}, 16'b001111);

    // Asynchronous reset mid-cycle
    drive(3'd7, 3'd7, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_rst_out", {10'b0, out}, 16'd0);
    check("async_rst_leds", leds, 16'h0000);
    tick(2);
    check("rst_held_leds", leds, 16'h0000);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
